// File: rtl/exec_share_arbiter_if.sv
// Request/response bundle between two requesters, the shared Execute datapath and the
// response consumer. master = requesters/Execute/consumer side, slave = arbiter side.
interface exec_share_arbiter_if #(
  parameter int unsigned OPCODE_BIT_WIDTH = 4,
  parameter int unsigned DBITS            = 32
);
  localparam int unsigned REQ_W = 4 + 2 * OPCODE_BIT_WIDTH + 16 + 4 * DBITS;

  logic             rq0_valid;
  logic             rq0_ready;
  logic [REQ_W-1:0] rq0_word;
  logic             rq1_valid;
  logic             rq1_ready;
  logic [REQ_W-1:0] rq1_word;
  logic [REQ_W-1:0] ex_word;
  logic [DBITS-1:0] ex_alu;
  logic             ex_cond;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [DBITS-1:0] rsp_data;
  logic             rsp_cond;

  modport slave (
    input  rq0_valid, rq0_word, rq1_valid, rq1_word, ex_alu, ex_cond, rsp_ready,
    output rq0_ready, rq1_ready, ex_word, rsp_valid, rsp_id, rsp_data, rsp_cond
  );

  modport master (
    output rq0_valid, rq0_word, rq1_valid, rq1_word, ex_alu, ex_cond, rsp_ready,
    input  rq0_ready, rq1_ready, ex_word, rsp_valid, rsp_id, rsp_data, rsp_cond
  );
endinterface

// File: rtl/exec_share_arbiter.sv
// Round-robin share of one combinational Execute unit between two requesters, with an
// issue register feeding Execute and a response register capturing its result.
module exec_share_arbiter #(
  parameter int unsigned OPCODE_BIT_WIDTH = 4,
  parameter int unsigned DBITS            = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  exec_share_arbiter_if.slave  bus
);
  localparam int unsigned REQ_W = 4 + 2 * OPCODE_BIT_WIDTH + 16 + 4 * DBITS;

  logic             iv_q, iv_d;
  logic [REQ_W-1:0] ireg_q, ireg_d;
  logic             iid_q, iid_d;
  logic             rv_q, rv_d;
  logic [DBITS-1:0] rdata_q, rdata_d;
  logic             rcond_q, rcond_d;
  logic             rid_q, rid_d;
  logic             rr_last_q, rr_last_d;

  logic adv_c;
  logic accept_ok_c;
  logic any_valid_c;
  logic grant_c;
  logic accept_c;

  // Handshake control; ready is held low while reset is asserted.
  always_comb begin
    adv_c       = iv_q & (~rv_q | bus.rsp_ready);
    accept_ok_c = reset_n & (~iv_q | adv_c);
    any_valid_c = bus.rq0_valid | bus.rq1_valid;
    if (bus.rq0_valid && bus.rq1_valid) begin
      grant_c = ~rr_last_q;
    end else begin
      grant_c = bus.rq1_valid;
    end
    accept_c      = accept_ok_c & any_valid_c;
    bus.rq0_ready = accept_c & ~grant_c;
    bus.rq1_ready = accept_c & grant_c;
  end

  // Next state for both pipeline stages and the round-robin pointer.
  always_comb begin
    iv_d      = iv_q;
    ireg_d    = ireg_q;
    iid_d     = iid_q;
    rr_last_d = rr_last_q;
    rv_d      = rv_q;
    rdata_d   = rdata_q;
    rcond_d   = rcond_q;
    rid_d     = rid_q;

    if (accept_c) begin
      ireg_d    = grant_c ? bus.rq1_word : bus.rq0_word;
      iid_d     = grant_c;
      iv_d      = 1'b1;
      rr_last_d = grant_c;
    end else if (adv_c) begin
      iv_d = 1'b0;
    end

    // A retiring response and a new capture in the same cycle simply reload the register.
    if (adv_c) begin
      rdata_d = bus.ex_alu;
      rcond_d = bus.ex_cond;
      rid_d   = iid_q;
      rv_d    = 1'b1;
    end else if (rv_q && bus.rsp_ready) begin
      rv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iv_q      <= 1'b0;
      ireg_q    <= '0;
      iid_q     <= 1'b0;
      rr_last_q <= 1'b1;
      rv_q      <= 1'b0;
      rdata_q   <= '0;
      rcond_q   <= 1'b0;
      rid_q     <= 1'b0;
    end else begin
      iv_q      <= iv_d;
      ireg_q    <= ireg_d;
      iid_q     <= iid_d;
      rr_last_q <= rr_last_d;
      rv_q      <= rv_d;
      rdata_q   <= rdata_d;
      rcond_q   <= rcond_d;
      rid_q     <= rid_d;
    end
  end

  assign bus.ex_word   = ireg_q;
  assign bus.rsp_valid = rv_q;
  assign bus.rsp_data  = rdata_q;
  assign bus.rsp_cond  = rcond_q;
  assign bus.rsp_id    = rid_q;

endmodule
